// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Round-robin arbiter sharing the single-port data memory between
//            the CPU MEM stage and a debug/loader port, with fixed latency.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int MEM_LAT = 2,
    parameter int AW      = 5
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cpu_req_i,
    input  logic          cpu_we_i,
    input  logic [31:0]   cpu_addr_i,
    input  logic [31:0]   cpu_wdata_i,
    output logic [31:0]   cpu_rdata_o,
    output logic          cpu_stall_o,
    input  logic          dbg_req_i,
    input  logic          dbg_we_i,
    input  logic [31:0]   dbg_addr_i,
    input  logic [31:0]   dbg_wdata_i,
    output logic [31:0]   dbg_rdata_o,
    output logic          dbg_ack_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    input  logic [31:0]   mem_rdata_i,
    output logic [31:0]   stall_cnt_o
);

    localparam logic [1:0] c_S_IDLE    = 2'd0;
    localparam logic [1:0] c_S_CPU_ACC = 2'd1;
    localparam logic [1:0] c_S_DBG_ACC = 2'd2;
    localparam logic [1:0] c_S_DBG_ACK = 2'd3;
    localparam logic [3:0] c_LAT_M1    = 4'(MEM_LAT - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        r_last_dbg;
    logic        w_last_dbg_nxt;
    logic [31:0] r_dbg_rdata;
    logic [31:0] w_dbg_rdata_nxt;
    logic [31:0] r_stall_cnt;

    logic        w_idle;
    logic        w_grant_cpu;
    logic        w_grant_dbg;
    logic        w_own_cpu;
    logic        w_own_dbg;
    logic [3:0]  w_cnt_cur;
    logic        w_done;
    logic        w_cpu_done;
    logic        w_unused_addr_bits;

    // Grants are masked during reset so the memory strobes drop at once.
    assign w_idle      = (r_state == c_S_IDLE);
    assign w_grant_cpu = w_idle && !rst_i && cpu_req_i && (!dbg_req_i || r_last_dbg);
    assign w_grant_dbg = w_idle && !rst_i && dbg_req_i && (!cpu_req_i || !r_last_dbg);
    assign w_own_cpu   = w_grant_cpu || (r_state == c_S_CPU_ACC);
    assign w_own_dbg   = w_grant_dbg || (r_state == c_S_DBG_ACC);
    assign w_cnt_cur   = w_idle ? c_LAT_M1 : r_cnt;
    assign w_done      = (w_own_cpu || w_own_dbg) && (w_cnt_cur == 4'd0);
    assign w_cpu_done  = w_own_cpu && w_done;

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_last_dbg_nxt  = r_last_dbg;
        w_dbg_rdata_nxt = r_dbg_rdata;
        if (w_own_cpu || w_own_dbg) begin
            w_cnt_nxt = w_done ? 4'd0 : (w_cnt_cur - 4'd1);
        end
        if (w_grant_cpu) begin
            w_last_dbg_nxt = 1'b0;
        end
        if (w_grant_dbg) begin
            w_last_dbg_nxt = 1'b1;
        end
        if (w_own_dbg && w_done) begin
            w_dbg_rdata_nxt = dbg_we_i ? 32'd0 : mem_rdata_i;
        end
        case (r_state)
            c_S_IDLE: begin
                if (w_grant_cpu) begin
                    w_state_nxt = w_done ? c_S_IDLE : c_S_CPU_ACC;
                end else if (w_grant_dbg) begin
                    w_state_nxt = w_done ? c_S_DBG_ACK : c_S_DBG_ACC;
                end
            end
            c_S_CPU_ACC: begin
                if (w_done) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            c_S_DBG_ACC: begin
                if (w_done) begin
                    w_state_nxt = c_S_DBG_ACK;
                end
            end
            c_S_DBG_ACK: w_state_nxt = c_S_IDLE;
            default:     w_state_nxt = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= c_S_IDLE;
            r_cnt       <= 4'd0;
            r_last_dbg  <= 1'b1;
            r_dbg_rdata <= 32'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_last_dbg  <= w_last_dbg_nxt;
            r_dbg_rdata <= w_dbg_rdata_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= 32'd0;
        end else if (cpu_stall_o && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign cpu_rdata_o = w_cpu_done ? mem_rdata_i : 32'd0;
    assign cpu_stall_o = cpu_req_i && !w_cpu_done;
    assign dbg_rdata_o = r_dbg_rdata;
    assign dbg_ack_o   = (r_state == c_S_DBG_ACK);
    assign stall_cnt_o = r_stall_cnt;

    // The owner's inputs pass straight through for the whole access.
    assign mem_en_o    = w_own_cpu || w_own_dbg;
    assign mem_we_o    = w_own_cpu ? cpu_we_i : (w_own_dbg ? dbg_we_i : 1'b0);
    assign mem_addr_o  = w_own_cpu ? cpu_addr_i[AW+1:2] :
                         (w_own_dbg ? dbg_addr_i[AW+1:2] : '0);
    assign mem_wdata_o = w_own_cpu ? cpu_wdata_i : (w_own_dbg ? dbg_wdata_i : 32'd0);

    assign w_unused_addr_bits = ^{cpu_addr_i[31:AW+2], cpu_addr_i[1:0],
                                  dbg_addr_i[31:AW+2], dbg_addr_i[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Self-checking bench for dmem_arbiter at MEM_LAT = 1, 2 and 3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cpu_req_i, cpu_we_i, dbg_req_i, dbg_we_i;
    logic [31:0] cpu_addr_i, cpu_wdata_i, dbg_addr_i, dbg_wdata_i;

    logic [31:0] cpu_rdata1, cpu_rdata2, cpu_rdata3;
    logic        cpu_stall1, cpu_stall2, cpu_stall3;
    logic [31:0] dbg_rdata1, dbg_rdata2, dbg_rdata3;
    logic        dbg_ack1, dbg_ack2, dbg_ack3;
    logic        mem_en1, mem_en2, mem_en3, mem_we1, mem_we2, mem_we3;
    logic [4:0]  mem_addr1, mem_addr2, mem_addr3;
    logic [31:0] mem_wdata1, mem_wdata2, mem_wdata3;
    logic [31:0] mem_rdata1, mem_rdata2, mem_rdata3;
    logic [31:0] stall_cnt1, stall_cnt2, stall_cnt3;
    logic [31:0] mem1 [32];
    logic [31:0] mem2 [32];
    logic [31:0] mem3 [32];

    logic [31:0] model [32];
    logic [31:0] q_cpu [$];
    logic [31:0] q_dbg [$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          exp_stall_tot;

    always #5 clk_i = ~clk_i;

    dmem_arbiter #(.MEM_LAT(1), .AW(5)) u_dut1 (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata1), .cpu_stall_o(cpu_stall1),
        .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
        .dbg_wdata_i(dbg_wdata_i), .dbg_rdata_o(dbg_rdata1), .dbg_ack_o(dbg_ack1),
        .mem_en_o(mem_en1), .mem_we_o(mem_we1), .mem_addr_o(mem_addr1),
        .mem_wdata_o(mem_wdata1), .mem_rdata_i(mem_rdata1), .stall_cnt_o(stall_cnt1)
    );
    dmem_arbiter #(.MEM_LAT(2), .AW(5)) u_dut2 (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata2), .cpu_stall_o(cpu_stall2),
        .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
        .dbg_wdata_i(dbg_wdata_i), .dbg_rdata_o(dbg_rdata2), .dbg_ack_o(dbg_ack2),
        .mem_en_o(mem_en2), .mem_we_o(mem_we2), .mem_addr_o(mem_addr2),
        .mem_wdata_o(mem_wdata2), .mem_rdata_i(mem_rdata2), .stall_cnt_o(stall_cnt2)
    );
    dmem_arbiter #(.MEM_LAT(3), .AW(5)) u_dut3 (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata3), .cpu_stall_o(cpu_stall3),
        .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
        .dbg_wdata_i(dbg_wdata_i), .dbg_rdata_o(dbg_rdata3), .dbg_ack_o(dbg_ack3),
        .mem_en_o(mem_en3), .mem_we_o(mem_we3), .mem_addr_o(mem_addr3),
        .mem_wdata_o(mem_wdata3), .mem_rdata_i(mem_rdata3), .stall_cnt_o(stall_cnt3)
    );

    // Single-port memories: combinational read, write on the clock edge.
    assign mem_rdata1 = mem1[mem_addr1];
    assign mem_rdata2 = mem2[mem_addr2];
    assign mem_rdata3 = mem3[mem_addr3];
    always @(posedge clk_i) begin
        if (mem_en1 && mem_we1) mem1[mem_addr1] <= mem_wdata1;
        if (mem_en2 && mem_we2) mem2[mem_addr2] <= mem_wdata2;
        if (mem_en3 && mem_we3) mem3[mem_addr3] <= mem_wdata3;
    end

    typedef struct {
        logic        c_req;
        logic        c_we;
        logic [31:0] c_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wd;
        logic        e_en;
        logic        e_we;
        logic [4:0]  e_addr;
        logic        e_stall;
        logic        e_ack;
    } row_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
    } txn_t;

    row_t rows [14];
    txn_t txns [7];

    function automatic row_t mk(input logic cr, input logic cw, input logic [31:0] ca,
                                input logic dr, input logic dw, input logic [31:0] da,
                                input logic [31:0] dd, input logic en, input logic we,
                                input logic [4:0] ad, input logic st, input logic ak);
        row_t r;
        r.c_req = cr; r.c_we = cw; r.c_addr = ca;
        r.d_req = dr; r.d_we = dw; r.d_addr = da; r.d_wd = dd;
        r.e_en = en; r.e_we = we; r.e_addr = ad; r.e_stall = st; r.e_ack = ak;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: no completion within the cycle budget", name);
    endtask

    task automatic pop_cmp(input string name, input logic [31:0] act, inout logic [31:0] q [$]);
        if (q.size() == 0) begin
            fail_now({name, "_unexpected_completion"});
        end else begin
            chk(name, act, q.pop_front());
        end
    endtask

    task automatic reset_pulse();
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
    endtask

    task automatic dbg_write(input logic [31:0] addr, input logic [31:0] wd);
        bit done = 1'b0;
        @(posedge clk_i); #1;
        dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = addr; dbg_wdata_i = wd;
        model[addr[6:2]] = wd;
        for (int c = 0; c < 10 && !done; c++) begin
            @(negedge clk_i);
            if (dbg_ack2) done = 1'b1;
            else begin @(posedge clk_i); #1; end
        end
        if (!done) fail_now("preload_ack");
        @(posedge clk_i); #1;
        dbg_req_i = 1'b0;
        repeat (2) @(posedge clk_i);
    endtask

    // One CPU access on the MEM_LAT=2 instance, checked every cycle it lasts.
    task automatic cpu_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        int          stalls = 0;
        bit          done   = 1'b0;
        logic [4:0]  w;
        w = addr[6:2];
        @(posedge clk_i); #1;
        cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_wdata_i = wd;
        if (we) model[w] = wd;
        q_cpu.push_back(model[w]);
        exp_stall_tot = exp_stall_tot + 1;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk_i);
            chk("txn_mem_en", 32'(mem_en2), 32'd1);
            chk("txn_mem_we", 32'(mem_we2), 32'(we));
            chk("txn_mem_addr", 32'(mem_addr2), 32'(w));
            if (!cpu_stall2) begin
                done = 1'b1;
                pop_cmp("txn_cpu_rdata", cpu_rdata2, q_cpu);
                chk("txn_stall_cnt", stall_cnt2, 32'(exp_stall_tot));
            end else begin
                stalls++;
                @(posedge clk_i); #1;
            end
        end
        if (!done) fail_now("txn_timeout");
        chk("txn_stall_cycles", 32'(stalls), 32'd1);
        @(posedge clk_i); #1;
        cpu_req_i = 1'b0;
        repeat (2) @(posedge clk_i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit cpu_pend = 1'b0;
        bit dbg_pend = 1'b0;

        txns[0] = '{1'b0, 32'h00, 32'h0};
        txns[1] = '{1'b1, 32'h08, 32'h7};
        txns[2] = '{1'b0, 32'h08, 32'h0};
        txns[3] = '{1'b0, 32'h7C, 32'h0};
        txns[4] = '{1'b0, 32'h84, 32'h0};
        txns[5] = '{1'b1, 32'h0C, 32'h1234_5678};
        txns[6] = '{1'b0, 32'h0C, 32'h0};

        //            cpu req/we/addr      dbg req/we/addr/wdata        en we addr st ack
        rows[0]  = mk(1, 0, 32'h04, 1, 0, 32'h00, 32'h00, 1, 0, 5'd1, 1, 0);
        rows[1]  = mk(1, 0, 32'h04, 1, 0, 32'h00, 32'h00, 1, 0, 5'd1, 0, 0);
        rows[2]  = mk(0, 0, 32'h04, 1, 0, 32'h00, 32'h00, 1, 0, 5'd0, 0, 0);
        rows[3]  = mk(0, 0, 32'h04, 1, 0, 32'h00, 32'h00, 1, 0, 5'd0, 0, 0);
        rows[4]  = mk(0, 0, 32'h04, 1, 0, 32'h00, 32'h00, 0, 0, 5'd0, 0, 1);
        rows[5]  = mk(0, 0, 32'h00, 0, 0, 32'h00, 32'h00, 0, 0, 5'd0, 0, 0);
        rows[6]  = mk(1, 0, 32'h00, 1, 1, 32'h10, 32'hA5, 1, 0, 5'd0, 1, 0);
        rows[7]  = mk(1, 0, 32'h00, 1, 1, 32'h10, 32'hA5, 1, 0, 5'd0, 0, 0);
        rows[8]  = mk(1, 0, 32'h1C, 1, 1, 32'h10, 32'hA5, 1, 1, 5'd4, 1, 0);
        rows[9]  = mk(1, 0, 32'h1C, 1, 1, 32'h10, 32'hA5, 1, 1, 5'd4, 1, 0);
        rows[10] = mk(1, 0, 32'h1C, 1, 1, 32'h10, 32'hA5, 0, 0, 5'd0, 1, 1);
        rows[11] = mk(1, 0, 32'h1C, 0, 0, 32'h00, 32'h00, 1, 0, 5'd7, 1, 0);
        rows[12] = mk(1, 0, 32'h1C, 0, 0, 32'h00, 32'h00, 1, 0, 5'd7, 0, 0);
        rows[13] = mk(0, 0, 32'h00, 0, 0, 32'h00, 32'h00, 0, 0, 5'd0, 0, 0);

        rst_i = 1'b1;
        cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0;
        dbg_req_i = 1'b0; dbg_we_i = 1'b0; dbg_addr_i = '0; dbg_wdata_i = '0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        repeat (2) @(negedge clk_i);
        chk("rst_mem_en", 32'(mem_en2), 32'd0);
        chk("rst_dbg_ack", 32'(dbg_ack2), 32'd0);
        chk("rst_dbg_rdata", dbg_rdata2, 32'd0);
        chk("rst_stall_cnt", stall_cnt2, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        // Preload through the debug port.
        dbg_write(32'h00, 32'd5);
        dbg_write(32'h04, 32'd9);
        for (int i = 2; i < 8; i++) dbg_write(32'(i * 4), 32'h100 + 32'(i));
        dbg_write(32'h7C, 32'hDEAD_BEEF);

        // CPU-only accesses at MEM_LAT=2, including address wrap at 0x84.
        reset_pulse();
        exp_stall_tot = 0;
        for (int i = 0; i < 7; i++) cpu_txn(txns[i].we, txns[i].addr, txns[i].wd);
        chk("store_word2", mem2[2], 32'd7);
        chk("store_word3", mem2[3], 32'h1234_5678);

        // Reset asserted in the middle of a debug access.
        @(posedge clk_i); #1;
        dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 32'h00;
        @(posedge clk_i); #1;
        chk("pre_rst_mem_en", 32'(mem_en2), 32'd1);
        #1 rst_i = 1'b1;
        #1;
        chk("mid_rst_mem_en", 32'(mem_en2), 32'd0);
        chk("mid_rst_mem_we", 32'(mem_we2), 32'd0);
        chk("mid_rst_stall", 32'(cpu_stall2), 32'd0);
        chk("mid_rst_cpu_rdata", cpu_rdata2, 32'd0);
        chk("mid_rst_dbg_ack", 32'(dbg_ack2), 32'd0);
        chk("mid_rst_dbg_rdata", dbg_rdata2, 32'd0);
        chk("mid_rst_stall_cnt", stall_cnt2, 32'd0);
        dbg_req_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        // Contention after reset, then DBG held against back-to-back CPU loads.
        for (int i = 0; i < 14; i++) begin
            @(posedge clk_i); #1;
            cpu_req_i = rows[i].c_req; cpu_we_i = rows[i].c_we; cpu_addr_i = rows[i].c_addr;
            cpu_wdata_i = '0;
            dbg_req_i = rows[i].d_req; dbg_we_i = rows[i].d_we; dbg_addr_i = rows[i].d_addr;
            dbg_wdata_i = rows[i].d_wd;
            if (cpu_req_i && !cpu_pend) begin
                q_cpu.push_back(model[cpu_addr_i[6:2]]);
                cpu_pend = 1'b1;
            end
            if (dbg_req_i && !dbg_pend) begin
                if (dbg_we_i) begin
                    model[dbg_addr_i[6:2]] = dbg_wdata_i;
                    q_dbg.push_back(32'd0);
                end else begin
                    q_dbg.push_back(model[dbg_addr_i[6:2]]);
                end
                dbg_pend = 1'b1;
            end
            @(negedge clk_i);
            chk($sformatf("row%0d_mem_en", i), 32'(mem_en2), 32'(rows[i].e_en));
            chk($sformatf("row%0d_mem_we", i), 32'(mem_we2), 32'(rows[i].e_we));
            chk($sformatf("row%0d_mem_addr", i), 32'(mem_addr2), 32'(rows[i].e_addr));
            chk($sformatf("row%0d_stall", i), 32'(cpu_stall2), 32'(rows[i].e_stall));
            chk($sformatf("row%0d_dbg_ack", i), 32'(dbg_ack2), 32'(rows[i].e_ack));
            if (cpu_req_i && !cpu_stall2) begin
                pop_cmp("row_cpu_rdata", cpu_rdata2, q_cpu);
                cpu_pend = 1'b0;
            end
            if (dbg_ack2) begin
                pop_cmp("row_dbg_rdata", dbg_rdata2, q_dbg);
                dbg_pend = 1'b0;
            end
        end
        chk("rows_stall_cnt", stall_cnt2, 32'd6);
        chk("dbg_store_word4", mem2[4], 32'hA5);

        // MEM_LAT=1: a load every cycle never stalls.
        reset_pulse();
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_i); #1;
            cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'(i * 4);
            q_cpu.push_back(model[i]);
            @(negedge clk_i);
            chk("l1_stall", 32'(cpu_stall1), 32'd0);
            pop_cmp("l1_cpu_rdata", cpu_rdata1, q_cpu);
        end
        @(posedge clk_i); #1;
        cpu_req_i = 1'b0;
        @(negedge clk_i);
        chk("l1_stall_cnt", stall_cnt1, 32'd0);

        // MEM_LAT=3: reset during a debug access abandons it without ack.
        reset_pulse();
        @(posedge clk_i); #1;
        dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 32'h00;
        @(negedge clk_i);
        chk("l3_dbg_grant", 32'(mem_en3), 32'd1);
        @(posedge clk_i); #1;
        chk("l3_dbg_acc", 32'(mem_en3), 32'd1);
        #1 rst_i = 1'b1;
        #1;
        chk("l3_rst_mem_en", 32'(mem_en3), 32'd0);
        chk("l3_rst_dbg_ack", 32'(dbg_ack3), 32'd0);
        dbg_req_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            chk("l3_post_rst_ack", 32'(dbg_ack3), 32'd0);
            chk("l3_post_rst_en", 32'(mem_en3), 32'd0);
        end
        @(posedge clk_i); #1;
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h04;
        q_cpu.push_back(model[1]);
        @(negedge clk_i);
        chk("l3_cpu_grant_en", 32'(mem_en3), 32'd1);
        chk("l3_cpu_grant_addr", 32'(mem_addr3), 32'd1);
        chk("l3_cpu_stall0", 32'(cpu_stall3), 32'd1);
        @(negedge clk_i);
        chk("l3_cpu_stall1", 32'(cpu_stall3), 32'd1);
        @(negedge clk_i);
        chk("l3_cpu_stall2", 32'(cpu_stall3), 32'd0);
        pop_cmp("l3_cpu_rdata", cpu_rdata3, q_cpu);
        @(posedge clk_i); #1;
        cpu_req_i = 1'b0;
        @(negedge clk_i);
        chk("l3_stall_cnt", stall_cnt3, 32'd2);

        chk("cpu_queue_drained", 32'(q_cpu.size()), 32'd0);
        chk("dbg_queue_drained", 32'(q_dbg.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
